// File: rtl/d_mux_pkg.sv
// Shared types and the default memory map for the data-bus decoder/multiplexer.
package d_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_CONFLICT = 2'd3
  } err_e;

  // Existing map: peripheral registers in the lower 8 KiB, RAM in the upper 8 KiB.
  // Slave 0 is the register block, slave 1 is RAM.
  localparam logic [13:0] REG_BASE = 14'h0000;
  localparam logic [13:0] REG_MASK = 14'h2000;
  localparam logic [13:0] RAM_BASE = 14'h2000;
  localparam logic [13:0] RAM_MASK = 14'h2000;

endpackage

// File: rtl/d_mux_decode.sv
// Combinational address decoder: first (lowest-index) matching region wins.
module d_mux_decode
  import d_mux_pkg::*;
#(
  parameter int unsigned                 ADDR_LEN = 14,
  parameter int unsigned                 NUM_SLV  = 2,
  parameter int unsigned                 SEL_W    = 1,
  parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_LEN-1:0] addr,
  output logic                hit,
  output logic [SEL_W-1:0]    sel,
  output logic [ADDR_LEN-3:0] offset
);

  localparam int unsigned OFF_W = ADDR_LEN - 2;

  // Scan upward and keep the first hit so overlapping regions resolve to the lowest index.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    offset = '0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (!hit && ((addr & SLV_MASK[k*ADDR_LEN +: ADDR_LEN]) == SLV_BASE[k*ADDR_LEN +: ADDR_LEN])) begin
        hit    = 1'b1;
        sel    = SEL_W'(k);
        offset = OFF_W'((addr & ~SLV_MASK[k*ADDR_LEN +: ADDR_LEN]) >> 2);
      end
    end
  end

endmodule

// File: rtl/d_mux_n.sv
// N-slave data-bus decoder/multiplexer with one outstanding transaction,
// valid/ready handshake, per-slave wait states and bus-error reporting.
module d_mux_n
  import d_mux_pkg::*;
#(
  parameter int unsigned                 XLEN     = 32,
  parameter int unsigned                 ADDR_LEN = 14,
  parameter int unsigned                 NUM_SLV  = 2,
  parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_BASE = {RAM_BASE, REG_BASE},
  parameter logic [NUM_SLV*ADDR_LEN-1:0] SLV_MASK = {RAM_MASK, REG_MASK},
  parameter int unsigned                 TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic [ADDR_LEN-1:0]       addr,
  input  logic                      rd_req,
  input  logic                      wr_req,
  input  logic [XLEN/8-1:0]         be,
  input  logic [XLEN-1:0]           wr_data,
  output logic [XLEN-1:0]           rd_data,
  output logic                      rd_ready,
  output logic                      wr_ready,
  output logic                      bus_err,
  output logic [1:0]                err_code,
  output logic [ADDR_LEN-1:0]       err_addr,
  output logic [NUM_SLV-1:0]        s_en,
  output logic [XLEN/8-1:0]         s_we,
  output logic [ADDR_LEN-3:0]       s_addr,
  output logic [XLEN-1:0]           s_wr_data,
  input  logic [NUM_SLV*XLEN-1:0]   s_rd_data,
  input  logic [NUM_SLV-1:0]        s_ready
);

  localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  rd_dir_q, rd_dir_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN/8-1:0]     s_we_q, s_we_d;
  logic [ADDR_LEN-3:0]   s_addr_q, s_addr_d;
  logic [XLEN-1:0]       s_wr_data_q, s_wr_data_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  bus_err_q, bus_err_d;
  err_e                  err_code_q, err_code_d;
  logic [ADDR_LEN-1:0]   err_addr_q, err_addr_d;

  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_sel;
  logic [ADDR_LEN-3:0]   dec_off;

  d_mux_decode #(
    .ADDR_LEN (ADDR_LEN),
    .NUM_SLV  (NUM_SLV),
    .SEL_W    (SEL_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr   (addr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .offset (dec_off)
  );

  // Next-state logic; ready/error outputs are computed on entry to RESP so they
  // are registered and visible for exactly the RESP cycle.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rd_dir_d    = rd_dir_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    s_we_d      = s_we_q;
    s_addr_d    = s_addr_q;
    s_wr_data_d = s_wr_data_q;
    rd_data_d   = rd_data_q;
    rd_ready_d  = 1'b0;
    wr_ready_d  = 1'b0;
    bus_err_d   = 1'b0;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    s_en        = '0;
    unique case (state_q)
      IDLE: begin
        if (rd_req && wr_req) begin
          state_d    = RESP;
          rd_ready_d = 1'b1;
          bus_err_d  = 1'b1;
          err_code_d = ERR_CONFLICT;
          err_addr_d = addr;
          rd_data_d  = '0;
        end else if (rd_req || wr_req) begin
          if (!dec_hit) begin
            state_d    = RESP;
            rd_ready_d = rd_req;
            wr_ready_d = wr_req;
            bus_err_d  = 1'b1;
            err_code_d = ERR_UNMAPPED;
            err_addr_d = addr;
            if (rd_req) rd_data_d = '0;
          end else begin
            s_en[dec_sel] = 1'b1;
            state_d       = WAIT;
            sel_d         = dec_sel;
            rd_dir_d      = rd_req;
            addr_d        = addr;
            cnt_d         = '0;
            s_we_d        = wr_req ? be : '0;
            s_addr_d      = dec_off;
            s_wr_data_d   = wr_data;
          end
        end
      end
      WAIT: begin
        if (s_ready[sel_q]) begin
          state_d    = RESP;
          rd_ready_d = rd_dir_q;
          wr_ready_d = !rd_dir_q;
          if (rd_dir_q) rd_data_d = s_rd_data[sel_q*XLEN +: XLEN];
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d    = RESP;
          rd_ready_d = rd_dir_q;
          wr_ready_d = !rd_dir_q;
          bus_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = addr_q;
          if (rd_dir_q) rd_data_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rd_dir_q    <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      s_we_q      <= '0;
      s_addr_q    <= '0;
      s_wr_data_q <= '0;
      rd_data_q   <= '0;
      rd_ready_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rd_dir_q    <= rd_dir_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_wr_data_q <= s_wr_data_d;
      rd_data_q   <= rd_data_d;
      rd_ready_q  <= rd_ready_d;
      wr_ready_q  <= wr_ready_d;
      bus_err_q   <= bus_err_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Slave-side fields show the new request in the accept cycle, then hold the latch.
  assign s_we      = s_we_d;
  assign s_addr    = s_addr_d;
  assign s_wr_data = s_wr_data_d;
  assign rd_data   = rd_data_q;
  assign rd_ready  = rd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign bus_err   = bus_err_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;

endmodule
